// File: rtl/prm_chk_pkg.sv
// Shared constants, FSM state type and debug helpers for the edge-mask collector
// and the prm_oblgc_chk* checker bank it feeds.
package prm_chk_pkg;

  localparam int CODE_W  = 15;
  localparam int NUM_CHK = 1024;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    PROBE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Code bit 0 drives checker input A, bit 14 drives input O.
  function automatic byte chk_letter(input int idx);
    return byte'(65 + idx);
  endfunction

endpackage

// File: rtl/prm_mask_accum.sv
// OR-accumulating blocked-edge register with clear/enable and a reduction-OR flag.
// Wide instances register per-chunk ORs of the next value so the flag stays aligned with acc.
module prm_mask_accum #(
  parameter int W = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc,
  output logic         any
);

  logic [W-1:0] acc_reg;
  logic [W-1:0] acc_next;

  always_comb begin
    acc_next = acc_reg;
    if (clr) begin
      acc_next = '0;
    end else if (en) begin
      acc_next = acc_reg | din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign acc = acc_reg;

  generate
    if (W > 2048) begin : g_piped_any
      localparam int CH  = 1024;
      localparam int NCH = (W + CH - 1) / CH;

      logic [NCH*CH-1:0] next_pad;
      logic [NCH-1:0]    part_reg;

      assign next_pad = (NCH*CH)'(acc_next);

      for (genvar gi = 0; gi < NCH; gi++) begin : g_chunk
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            part_reg[gi] <= 1'b0;
          end else begin
            part_reg[gi] <= |next_pad[gi*CH +: CH];
          end
        end
      end

      assign any = |part_reg;
    end else begin : g_flat_any
      assign any = |acc_reg;
    end
  endgenerate

endmodule

// File: rtl/prm_edge_mask_collector.sv
// Feeds batched voxel codes to the shared checker bank one at a time and ORs the
// returned edge masks into one blocked-edge word per batch for the pruning stage.
module prm_edge_mask_collector #(
  parameter int CODE_W  = prm_chk_pkg::CODE_W,
  parameter int NUM_CHK = prm_chk_pkg::NUM_CHK,
  parameter int CNT_W   = 16
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CODE_W-1:0]  in_code,
  input  logic               in_last,
  input  logic               flush,
  output logic [CODE_W-1:0]  chk_code,
  input  logic [NUM_CHK-1:0] chk_mask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_CHK-1:0] out_mask,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_any
);

  import prm_chk_pkg::*;

  state_t             state_reg;
  state_t             state_next;
  logic [CODE_W-1:0]  code_reg;
  logic               last_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               acc_clr;
  logic               acc_en;
  logic               accept;
  logic [NUM_CHK-1:0] acc;
  logic               acc_any;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    case (state_reg)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) state_next = PROBE;
      end
      PROBE: begin
        acc_en     = 1'b1;
        state_next = last_reg ? DONE : ACCUM;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          acc_clr    = 1'b1;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
    // Flush beats everything, including a code offered in the same cycle.
    if (flush) begin
      in_ready   = 1'b0;
      acc_clr    = 1'b1;
      acc_en     = 1'b0;
      state_next = ACCUM;
    end
  end

  assign accept = in_ready & in_valid;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg <= ACCUM;
      code_reg  <= '0;
      last_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (flush) begin
        last_reg <= 1'b0;
        cnt_reg  <= '0;
      end else begin
        if (accept) begin
          code_reg <= in_code;
          last_reg <= in_last;
        end
        if (state_reg == PROBE && cnt_reg != {CNT_W{1'b1}}) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (state_reg == DONE && out_ready) begin
          cnt_reg <= '0;
        end
      end
    end
  end

  prm_mask_accum #(
    .W(NUM_CHK)
  ) u_accum (
    .clk   (CLK),
    .rst_n (RST_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .din   (chk_mask),
    .acc   (acc),
    .any   (acc_any)
  );

  assign chk_code  = code_reg;
  assign out_mask  = out_valid ? acc : '0;
  assign out_count = out_valid ? cnt_reg : '0;
  assign out_any   = out_valid & acc_any;

endmodule

// File: tb/tb_prm_edge_mask_collector.sv
// Randomized bench for prm_edge_mask_collector: a behavioural checker bank supplies
// chk_mask, and each batch result is predicted as the OR of its codes' masks.
module tb_prm_edge_mask_collector;

  localparam int CW   = 15;
  localparam int NC   = 1024;
  localparam int CNTW = 4;
  localparam int SAT  = 15;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_code = '0;
  logic          in_last = 1'b0;
  logic          flush = 1'b0;
  logic [CW-1:0] chk_code;
  logic [NC-1:0] chk_mask;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [NC-1:0] out_mask;
  logic [CNTW-1:0] out_count;
  logic          out_any;

  int checks = 0;
  int errors = 0;

  logic [NC-1:0]  tbl [int];
  logic [CW-1:0]  batch_q [$];

  always #5 CLK = ~CLK;

  prm_edge_mask_collector #(
    .CODE_W(CW), .NUM_CHK(NC), .CNT_W(CNTW)
  ) dut (
    .CLK(CLK), .RST_n(RST_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_last(in_last),
    .flush(flush), .chk_code(chk_code), .chk_mask(chk_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mask(out_mask), .out_count(out_count), .out_any(out_any)
  );

  // Behavioural checker bank: fixed entries for directed codes, a hash for the rest.
  function automatic logic [NC-1:0] mask_for(input logic [CW-1:0] c);
    logic [NC-1:0] m;
    m = '0;
    if (tbl.exists(int'(c))) return tbl[int'(c)];
    m[int'(c) % NC] = 1'b1;
    m[(int'(c) * 13 + 7) % NC] = 1'b1;
    return m;
  endfunction

  assign chk_mask = mask_for(chk_code);

  function automatic int sat_cnt(input int n);
    return (n > SAT) ? SAT : n;
  endfunction

  task automatic send_code(input logic [CW-1:0] c, input logic l);
    bit ok;
    in_valid = 1'b1; in_code = c; in_last = l;
    #1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge CLK); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_code_timeout code=%h got in_ready=0 want 1 within 20 cycles", c);
    end
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Sends batch_q as one batch, predicts its result and waits for out_valid.
  task automatic drive_batch(output logic [NC-1:0] em, output int en, output int lat);
    em = '0; en = 0;
    foreach (batch_q[i]) begin
      send_code(batch_q[i], i == batch_q.size() - 1);
      em |= mask_for(batch_q[i]);
      en++;
    end
    #1;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge CLK); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || chk_code !== '0 ||
        out_mask !== '0 || out_count !== '0 || out_any !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b code=%h cnt=%0d any=%b want rdy=1 vld=0 code=0 cnt=0 any=0",
               in_ready, out_valid, chk_code, out_count, out_any);
    end
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mask !== '0 || out_count !== '0) begin
        errors++;
        $display("FAIL idle_cycle%0d got rdy=%b vld=%b cnt=%0d want rdy=1 vld=0 cnt=0",
                 i, in_ready, out_valid, out_count);
      end
    end
    $display("test_reset: idle for 10 cycles after reset");
  endtask

  task automatic consume(input string name);
    @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_mask !== '0) begin
      errors++;
      $display("FAIL %s_release got vld=%b rdy=%b want vld=0 rdy=1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_single();
    logic [NC-1:0] em; int en, lat; string s;
    batch_q = {15'h2E89};
    s = "";
    for (int b = CW - 1; b >= 0; b--) if (batch_q[0][b]) s = {s, string'(prm_chk_pkg::chk_letter(b))};
    drive_batch(em, en, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL single_latency got %0d want 2", lat); end
    checks++;
    if (out_mask !== em || out_mask[729] !== 1'b1 || $countones(out_mask) != 1) begin
      errors++;
      $display("FAIL single_mask got %0d bits (bit729=%b) want 1 bit at 729", $countones(out_mask), out_mask[729]);
    end
    checks++;
    if (out_count !== CNTW'(1) || out_any !== 1'b1) begin
      errors++;
      $display("FAIL single_count_any got cnt=%0d any=%b want cnt=1 any=1", out_count, out_any);
    end
    $display("test_single: code=%h high inputs=%s count=%0d", batch_q[0], s, out_count);
    consume("single");
  endtask

  task automatic test_hold();
    logic [NC-1:0] em; int en, lat;
    batch_q = {15'h0011, 15'h0022, 15'h0033};
    drive_batch(em, en, lat);
    checks++;
    if (out_mask !== em || !out_mask[0] || !out_mask[3] || !out_mask[700] || $countones(out_mask) != 3 ||
        out_count !== CNTW'(3)) begin
      errors++;
      $display("FAIL hold_result got %0d bits cnt=%0d want bits {0,3,700} cnt=3", $countones(out_mask), out_count);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_mask !== em || out_count !== CNTW'(3) || out_any !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d got vld=%b rdy=%b cnt=%0d want vld=1 rdy=0 cnt=3 stable", i, out_valid, in_ready, out_count);
      end
    end
    $display("test_hold: 3-code batch held 5 cycles, count=%0d", out_count);
    consume("hold");
  endtask

  task automatic test_flush();
    logic [NC-1:0] em; int en, lat;
    send_code(CW'($urandom_range(0, 32767)), 1'b0);
    send_code(CW'($urandom_range(0, 32767)), 1'b0);
    @(negedge CLK);
    flush = 1'b1; in_valid = 1'b1; in_code = CW'($urandom_range(0, 32767)); in_last = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    @(negedge CLK);
    flush = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    batch_q = {15'h0055};
    drive_batch(em, en, lat);
    checks++;
    if (out_mask !== em || !out_mask[5] || $countones(out_mask) != 1 || out_count !== CNTW'(1)) begin
      errors++;
      $display("FAIL flush_after got %0d bits cnt=%0d want only bit 5 cnt=1", $countones(out_mask), out_count);
    end
    // A pending result is discarded when flushed in the done state.
    @(negedge CLK);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_done got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
    end
    batch_q = {CW'($urandom_range(0, 32767))};
    drive_batch(em, en, lat);
    checks++;
    if (out_mask !== em || out_count !== CNTW'(1)) begin
      errors++;
      $display("FAIL flush_done_next got cnt=%0d want 1 (mask match=%b)", out_count, out_mask === em);
    end
    $display("test_flush: flushed partial batch and pending result");
    consume("flush");
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] codes [6];
    logic [NC-1:0] em [2];
    logic [NC-1:0] got_mask [2];
    int got_cnt [2];
    int acc_cyc [6];
    int idx, nres;
    for (int i = 0; i < 6; i++) codes[i] = CW'($urandom_range(0, 32767));
    em[0] = mask_for(codes[0]) | mask_for(codes[1]) | mask_for(codes[2]);
    em[1] = mask_for(codes[3]) | mask_for(codes[4]) | mask_for(codes[5]);
    idx = 0; nres = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nres < 2; cyc++) begin
      @(negedge CLK);
      in_valid = (idx < 6);
      in_code  = codes[idx < 6 ? idx : 5];
      in_last  = (idx == 2 || idx == 5);
      #1;
      if (out_valid) begin
        got_mask[nres] = out_mask;
        got_cnt[nres]  = int'(out_count);
        nres++;
      end
      if (in_valid && in_ready) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
    end
    @(negedge CLK);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    checks++;
    if (idx != 6 || nres != 2) begin
      errors++;
      $display("FAIL b2b_counts got accepted=%0d results=%0d want 6 and 2", idx, nres);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (acc_cyc[i+1] - acc_cyc[i] != ((i == 2) ? 3 : 2)) begin
          errors++;
          $display("FAIL b2b_spacing%0d got %0d want %0d", i, acc_cyc[i+1] - acc_cyc[i], (i == 2) ? 3 : 2);
        end
      end
      for (int b = 0; b < 2; b++) begin
        checks++;
        if (got_mask[b] !== em[b] || got_cnt[b] != 3) begin
          errors++;
          $display("FAIL b2b_batch%0d got %0d bits cnt=%0d want %0d bits cnt=3",
                   b, $countones(got_mask[b]), got_cnt[b], $countones(em[b]));
        end
      end
    end
    $display("test_back_to_back: accepted=%0d results=%0d", idx, nres);
  endtask

  task automatic test_saturation();
    logic [NC-1:0] em; int en, lat;
    batch_q.delete();
    for (int i = 0; i < 20; i++) batch_q.push_back(CW'($urandom_range(0, 32767)));
    drive_batch(em, en, lat);
    checks++;
    if (out_count !== CNTW'(sat_cnt(en)) || out_mask !== em || out_any !== (em != '0)) begin
      errors++;
      $display("FAIL saturation got cnt=%0d bits=%0d any=%b want cnt=%0d bits=%0d",
               out_count, $countones(out_mask), out_any, sat_cnt(en), $countones(em));
    end
    $display("test_saturation: %0d codes count=%0d", en, out_count);
    consume("saturation");
  endtask

  task automatic test_reset_mid();
    logic [NC-1:0] em; int en, lat;
    send_code(CW'($urandom_range(0, 32767)), 1'b1);
    RST_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || chk_code !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL reset_mid got vld=%b rdy=%b code=%h want vld=0 rdy=1 code=0", out_valid, in_ready, chk_code);
    end
    @(negedge CLK); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_hold got vld=%b want 0", out_valid); end
    RST_n = 1'b1;
    batch_q = {CW'($urandom_range(0, 32767))};
    drive_batch(em, en, lat);
    checks++;
    if (out_mask !== em || out_count !== CNTW'(1)) begin
      errors++;
      $display("FAIL reset_mid_next got cnt=%0d bits=%0d want cnt=1 bits=%0d",
               out_count, $countones(out_mask), $countones(em));
    end
    $display("test_reset_mid: state cleared, next batch count=%0d", out_count);
    consume("reset_mid");
  endtask

  initial begin
    logic [NC-1:0] m;
    m = '0; m[729] = 1'b1; tbl[32'h2E89] = m;
    m = '0; m[3] = 1'b1; tbl[32'h0011] = m;
    m = '0; m[3] = 1'b1; m[700] = 1'b1; tbl[32'h0022] = m;
    m = '0; m[0] = 1'b1; tbl[32'h0033] = m;
    m = '0; m[5] = 1'b1; tbl[32'h0055] = m;
    test_reset();
    test_single();
    test_hold();
    test_flush();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
